vme_request_sync: RTL and testbench
===================================

Name: vme_request_sync

Overview:
- Front-end stage directly upstream of the VME data-transfer state machine on the k30p CPU card.
- Synchronises the asynchronous 68030 and VME control strobes into the `clock` domain.
- Decodes the CPU address into A16/A24/A40 VME windows and produces the `request_vme`/`_sync` qualifiers that the transfer FSM and bus arbiter consume.
- Runs a bus-timeout watchdog that flags a cycle the VME slave never terminates.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of every input synchroniser; legal range is 2 or more.
- A16_PREFIX, 16'hFFFF: value of cpu_address[31:16] that selects the A16 window.
- A24_PREFIX, 8'hFE: value of cpu_address[31:24] that selects the A24 window.
- A40_PREFIX, 8'hFD: value of cpu_address[31:24] that selects the A40 window.
- TIMEOUT_CYCLES, 1024: clocks allowed in ACTIVE before the watchdog fires; minimum 2.

Ports:
- clock  in  1  system clock; all logic uses the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_as  in  1  CPU address strobe; asynchronous, active-low.
- cpu_ds  in  1  CPU data strobe; asynchronous, active-low.
- cpu_address  in  16  CPU A[31:16]; stable while cpu_as is low.
- vme_dtack  in  1  VME DTACK*; asynchronous, active-low.
- vme_berr  in  1  VME BERR*; asynchronous, active-low.
- bus_acquired  in  1  output of the arbiter; asynchronous, active-low.
- cpu_as_sync  out  1  synchronised cpu_as.
- cpu_ds_sync  out  1  synchronised cpu_ds.
- vme_dtack_sync  out  1  synchronised vme_dtack.
- vme_berr_sync  out  1  synchronised vme_berr.
- bus_acquired_sync  out  1  synchronised bus_acquired.
- request_vme  out  1  to the arbiter; active-low; low in ACTIVE, DONE and TIMEOUT.
- request_vme_sync  out  1  to the transfer FSM; active-low; same timing as request_vme.
- request_vme_a16  out  1  active-low window flag, latched for the cycle.
- request_vme_a24  out  1  active-low window flag, latched for the cycle.
- request_vme_a40  out  1  active-low window flag, latched for the cycle.
- timeout_berr  out  1  active-low; drives CPU BERR on a watchdog expiry.

Behaviour:
- Reset (synchronous, active-high):
  - All synchroniser flops load 1.
  - State goes to IDLE and the counter to 0.
  - Every output is 1 (inactive) at the first edge after reset is sampled high.
  - Reset asserted mid-cycle forces the same values on the next edge, with no release sequence.
- Synchronisers:
  - Each async input passes through SYNC_STAGES flops.
  - An input edge appears on its `*_sync` output SYNC_STAGES rising edges after it is first sampled.
  - Sync outputs are direct flop outputs, never combinational.
- Decode (combinational on registered cpu_address, evaluated only in IDLE), priority A16 > A24 > A40:
  - A16 hit: cpu_address == A16_PREFIX.
  - A24 hit: cpu_address[15:8] == A24_PREFIX and not an A16 hit.
  - A40 hit: cpu_address[15:8] == A40_PREFIX and not an A16 or A24 hit.
  - At most one window flag is ever low.
- State machine:
  - IDLE:
    - Requests, flags and timeout_berr are 1.
    - If cpu_as_sync == 0 and a window hits: go to ACTIVE; request_vme, request_vme_sync and the matching flag go low on the same edge; counter := 0.
    - If cpu_as_sync == 0 and no window hits: go to IGNORE.
  - IGNORE:
    - All outputs inactive; the cycle belongs to on-board logic.
    - Go to IDLE when cpu_as_sync == 1.
  - ACTIVE:
    - Counter increments each clock.
    - If vme_dtack_sync == 0 or vme_berr_sync == 0: go to DONE.
    - Else if counter == TIMEOUT_CYCLES-1: go to TIMEOUT and timeout_berr := 0.
    - cpu_as_sync == 1 has highest priority: go to IDLE with all outputs released on the same edge.
  - DONE:
    - Request and flag held low; counter frozen.
    - Go to IDLE when cpu_as_sync == 1.
  - TIMEOUT:
    - request_vme_sync and timeout_berr held low.
    - Go to IDLE when cpu_as_sync == 1; both return to 1 on that edge.
- Window flags and the latched address never change between IDLE exits, even if cpu_address moves.
- Counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Saturates and never wraps.
  - Cleared on entry to ACTIVE.
- Simultaneous DTACK and timeout-terminal count resolve to DONE; timeout_berr stays 1.
- Back-to-back cycles: AS low again one clock after an IDLE return is decoded normally, with no dead cycle beyond the IDLE clock.

Test Plan:
- Reset held 3 clocks with cpu_as = 0 -> all outputs 1; then reset = 0 -> cpu_as_sync = 0 after 2 edges and FSM enters ACTIVE.
- cpu_address = 16'hFE12, cpu_as falls -> request_vme_a24 and request_vme_sync low 3 edges later; a16/a40 stay 1.
- A24 cycle, vme_dtack falls 10 clocks in -> DONE after 2 sync edges; cpu_as rises -> all requests 1 within 3 edges; timeout_berr never 0.
- TIMEOUT_CYCLES = 16, A16 cycle (16'hFFFF), no DTACK -> timeout_berr = 0 exactly 16 clocks after ACTIVE entry; released when cpu_as_sync returns to 1.
- cpu_address = 16'h0123 -> IGNORE; all request outputs stay 1 for the whole strobe.
- vme_dtack_sync falls on the same edge as counter == TIMEOUT_CYCLES-1 -> DONE, timeout_berr = 1; separately, reset pulsed in ACTIVE -> all outputs 1 next edge.

Source files
------------

// File: rtl/vme_request_sync.sv
// vme_request_sync
// Front end of the VME master path on the k30p CPU card. Brings the
// asynchronous 68030 strobes and VME termination strobes into the clock
// domain, decodes the CPU address into the A16/A24/A40 VME windows, raises
// the active-low request qualifiers for the arbiter and transfer FSM, and
// watches for a VME cycle that is never terminated.
//
// Handshake: there is no valid/ready pair here. A cycle is "offered" while
// cpu_as_sync is 0; it is "accepted" on the edge the FSM leaves IDLE, and
// it is retired on the edge cpu_as_sync returns to 1. Every request, window
// flag and timeout_berr is a registered output that changes only on those
// edges, so downstream logic never sees a combinational glitch.

module vme_request_sync #(
   parameter int          SYNC_STAGES    = 2,
   parameter logic [15:0] A16_PREFIX     = 16'hFFFF,
   parameter logic [7:0]  A24_PREFIX     = 8'hFE,
   parameter logic [7:0]  A40_PREFIX     = 8'hFD,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_as,
   input  logic        cpu_ds,
   input  logic [15:0] cpu_address,
   input  logic        vme_dtack,
   input  logic        vme_berr,
   input  logic        bus_acquired,
   output logic        cpu_as_sync,
   output logic        cpu_ds_sync,
   output logic        vme_dtack_sync,
   output logic        vme_berr_sync,
   output logic        bus_acquired_sync,
   output logic        request_vme,
   output logic        request_vme_sync,
   output logic        request_vme_a16,
   output logic        request_vme_a24,
   output logic        request_vme_a40,
   output logic        timeout_berr,
   output logic [2:0]  dbg_state
);

   // Counter must hold TIMEOUT_CYCLES itself so it can saturate without wrap.
   localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_IGNORE  = 3'd1,
      S_ACTIVE  = 3'd2,
      S_DONE    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers: one shift register per asynchronous strobe.
   // Bit 0 is the metastability-catching stage; the top bit is the output.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_as_pipe;
   logic [SYNC_STAGES-1:0] r_ds_pipe;
   logic [SYNC_STAGES-1:0] r_dtack_pipe;
   logic [SYNC_STAGES-1:0] r_berr_pipe;
   logic [SYNC_STAGES-1:0] r_acq_pipe;

   // Shift every strobe one stage per clock; reset parks them all inactive.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_as_pipe    <= '1;
         r_ds_pipe    <= '1;
         r_dtack_pipe <= '1;
         r_berr_pipe  <= '1;
         r_acq_pipe   <= '1;
      end else begin
         r_as_pipe    <= {r_as_pipe[SYNC_STAGES-2:0],    cpu_as};
         r_ds_pipe    <= {r_ds_pipe[SYNC_STAGES-2:0],    cpu_ds};
         r_dtack_pipe <= {r_dtack_pipe[SYNC_STAGES-2:0], vme_dtack};
         r_berr_pipe  <= {r_berr_pipe[SYNC_STAGES-2:0],  vme_berr};
         r_acq_pipe   <= {r_acq_pipe[SYNC_STAGES-2:0],   bus_acquired};
      end
   end

   logic w_as_sync;
   logic w_dtack_sync;
   logic w_berr_sync;

   assign w_as_sync    = r_as_pipe[SYNC_STAGES-1];
   assign w_dtack_sync = r_dtack_pipe[SYNC_STAGES-1];
   assign w_berr_sync  = r_berr_pipe[SYNC_STAGES-1];

   assign cpu_as_sync       = r_as_pipe[SYNC_STAGES-1];
   assign cpu_ds_sync       = r_ds_pipe[SYNC_STAGES-1];
   assign vme_dtack_sync    = r_dtack_pipe[SYNC_STAGES-1];
   assign vme_berr_sync     = r_berr_pipe[SYNC_STAGES-1];
   assign bus_acquired_sync = r_acq_pipe[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Address capture. The CPU holds the address stable while AS is low,
   // and AS needs SYNC_STAGES clocks to reach the FSM, so one register
   // stage is enough for the decode to see a settled value.
   // ------------------------------------------------------------------
   logic [15:0] r_addr;

   // Register the raw CPU address every clock for the window decode.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_addr <= '0;
      end else begin
         r_addr <= cpu_address;
      end
   end

   // Window decode, priority A16 > A24 > A40, so at most one hit is set.
   logic w_hit_a16;
   logic w_hit_a24;
   logic w_hit_a40;
   logic w_hit_any;

   assign w_hit_a16 = (r_addr == A16_PREFIX);
   assign w_hit_a24 = (r_addr[15:8] == A24_PREFIX) && !w_hit_a16;
   assign w_hit_a40 = (r_addr[15:8] == A40_PREFIX) && !w_hit_a16 && !w_hit_a24;
   assign w_hit_any = w_hit_a16 || w_hit_a24 || w_hit_a40;

   // ------------------------------------------------------------------
   // Request FSM with watchdog counter. All outputs are registered and
   // updated alongside the state so they switch on the transition edge.
   // ------------------------------------------------------------------
   state_t        r_state;
   logic [CW-1:0] r_count;
   logic          r_req;
   logic          r_req_sync;
   logic          r_a16;
   logic          r_a24;
   logic          r_a40;
   logic          r_tberr;

   // Sequence one CPU strobe through decode, VME request and termination.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_req      <= 1'b1;
         r_req_sync <= 1'b1;
         r_a16      <= 1'b1;
         r_a24      <= 1'b1;
         r_a40      <= 1'b1;
         r_tberr    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Window flags are only loaded here, so they hold for the
               // whole cycle even if cpu_address moves afterwards.
               if (!w_as_sync) begin
                  if (w_hit_any) begin
                     r_state    <= S_ACTIVE;
                     r_count    <= '0;
                     r_req      <= 1'b0;
                     r_req_sync <= 1'b0;
                     r_a16      <= !w_hit_a16;
                     r_a24      <= !w_hit_a24;
                     r_a40      <= !w_hit_a40;
                     r_tberr    <= 1'b1;
                  end else begin
                     r_state <= S_IGNORE;
                  end
               end
            end

            S_IGNORE: begin
               // Cycle is for on-board logic; just wait for the strobe to end.
               if (w_as_sync) begin
                  r_state <= S_IDLE;
               end
            end

            S_ACTIVE: begin
               if (w_as_sync) begin
                  // CPU abandoned the cycle: release everything at once.
                  r_state    <= S_IDLE;
                  r_req      <= 1'b1;
                  r_req_sync <= 1'b1;
                  r_a16      <= 1'b1;
                  r_a24      <= 1'b1;
                  r_a40      <= 1'b1;
                  r_tberr    <= 1'b1;
               end else begin
                  if (r_count != CNT_SAT) begin
                     r_count <= r_count + CNT_ONE;
                  end
                  // A slave termination wins over a watchdog expiry that
                  // lands on the same edge.
                  if (!w_dtack_sync || !w_berr_sync) begin
                     r_state <= S_DONE;
                  end else if (r_count == CNT_TERM) begin
                     r_state <= S_TIMEOUT;
                     r_tberr <= 1'b0;
                  end
               end
            end

            S_DONE, S_TIMEOUT: begin
               // Hold request (and timeout_berr in TIMEOUT) until AS rises.
               if (w_as_sync) begin
                  r_state    <= S_IDLE;
                  r_req      <= 1'b1;
                  r_req_sync <= 1'b1;
                  r_a16      <= 1'b1;
                  r_a24      <= 1'b1;
                  r_a40      <= 1'b1;
                  r_tberr    <= 1'b1;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_req      <= 1'b1;
               r_req_sync <= 1'b1;
               r_a16      <= 1'b1;
               r_a24      <= 1'b1;
               r_a40      <= 1'b1;
               r_tberr    <= 1'b1;
            end
         endcase
      end
   end

   assign request_vme      = r_req;
   assign request_vme_sync = r_req_sync;
   assign request_vme_a16  = r_a16;
   assign request_vme_a24  = r_a24;
   assign request_vme_a40  = r_a40;
   assign timeout_berr     = r_tberr;
   assign dbg_state        = r_state;

endmodule

// File: tb/tb_vme_request_sync.sv
// Directed bench for vme_request_sync (TIMEOUT_CYCLES = 16, SYNC_STAGES = 2).
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_vme_request_sync;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_IGNORE  = 3'd1;
   localparam logic [2:0] ST_ACTIVE  = 3'd2;
   localparam logic [2:0] ST_DONE    = 3'd3;
   localparam logic [2:0] ST_TIMEOUT = 3'd4;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_as;
   logic        cpu_ds;
   logic [15:0] cpu_address;
   logic        vme_dtack;
   logic        vme_berr;
   logic        bus_acquired;
   logic        cpu_as_sync;
   logic        cpu_ds_sync;
   logic        vme_dtack_sync;
   logic        vme_berr_sync;
   logic        bus_acquired_sync;
   logic        request_vme;
   logic        request_vme_sync;
   logic        request_vme_a16;
   logic        request_vme_a24;
   logic        request_vme_a40;
   logic        timeout_berr;
   logic [2:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   vme_request_sync #(
      .SYNC_STAGES   (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .cpu_as           (cpu_as),
      .cpu_ds           (cpu_ds),
      .cpu_address      (cpu_address),
      .vme_dtack        (vme_dtack),
      .vme_berr         (vme_berr),
      .bus_acquired     (bus_acquired),
      .cpu_as_sync      (cpu_as_sync),
      .cpu_ds_sync      (cpu_ds_sync),
      .vme_dtack_sync   (vme_dtack_sync),
      .vme_berr_sync    (vme_berr_sync),
      .bus_acquired_sync(bus_acquired_sync),
      .request_vme      (request_vme),
      .request_vme_sync (request_vme_sync),
      .request_vme_a16  (request_vme_a16),
      .request_vme_a24  (request_vme_a24),
      .request_vme_a40  (request_vme_a40),
      .timeout_berr     (timeout_berr),
      .dbg_state        (dbg_state)
   );

   // Clock: 10 ns period.
   always #5 clock = ~clock;

   // Global time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected value of the six request-side outputs, packed
   // {request_vme, request_vme_sync, a16, a24, a40, timeout_berr}.
   task automatic check_req(input string tag, input logic [5:0] exp);
      check(tag, {10'd0, request_vme, request_vme_sync, request_vme_a16,
                  request_vme_a24, request_vme_a40, timeout_berr}, {10'd0, exp});
   endtask

   task automatic check_state(input string tag, input logic [2:0] exp);
      check(tag, {13'd0, dbg_state}, {13'd0, exp});
   endtask

   task automatic check_syncs(input string tag, input logic [4:0] exp);
      check(tag, {11'd0, cpu_as_sync, cpu_ds_sync, vme_dtack_sync, vme_berr_sync,
                  bus_acquired_sync}, {11'd0, exp});
   endtask

   initial begin
      reset        = 1'b1;
      cpu_as       = 1'b0;
      cpu_ds       = 1'b1;
      cpu_address  = 16'hFFFF;
      vme_dtack    = 1'b1;
      vme_berr     = 1'b1;
      bus_acquired = 1'b1;

      // --- Reset held 3 clocks with AS low: everything inactive ---
      tick(3);
      check_syncs("rst_syncs", 5'b11111);
      check_req("rst_req", 6'b111111);
      check_state("rst_state", ST_IDLE);

      // --- Release: AS reaches sync after 2 edges, ACTIVE on the 3rd (A16) ---
      reset = 1'b0;
      tick(1);
      check("rel_as_e1", {15'd0, cpu_as_sync}, 16'd1);
      tick(1);
      check("rel_as_e2", {15'd0, cpu_as_sync}, 16'd0);
      check_state("rel_state_e2", ST_IDLE);
      tick(1);
      check_state("rel_state_e3", ST_ACTIVE);
      check_req("rel_req_a16", 6'b000111);
      cpu_as = 1'b1;
      tick(2);
      check_state("rel_abort_hold", ST_ACTIVE);
      tick(1);
      check_state("rel_abort_idle", ST_IDLE);
      check_req("rel_abort_req", 6'b111111);

      // --- Synchroniser latency on DS and bus_acquired ---
      cpu_ds = 1'b0;
      bus_acquired = 1'b0;
      tick(1);
      check_syncs("ds_acq_e1", 5'b11111);
      tick(1);
      check_syncs("ds_acq_e2", 5'b10110);
      cpu_ds = 1'b1;
      bus_acquired = 1'b1;
      tick(2);
      check_syncs("ds_acq_back", 5'b11111);

      // --- A24 cycle, DTACK 10 clocks after AS falls ---
      cpu_address = 16'hFE12;
      cpu_as = 1'b0;
      tick(2);
      check_req("a24_e2", 6'b111111);
      tick(1);
      check_state("a24_state", ST_ACTIVE);
      check_req("a24_req", 6'b001011);
      tick(7);
      vme_dtack = 1'b0;
      tick(2);
      check_state("a24_dtack_sync", ST_ACTIVE);
      check("a24_dtack_s", {15'd0, vme_dtack_sync}, 16'd0);
      cpu_address = 16'h0123;
      tick(1);
      check_state("a24_done", ST_DONE);
      check_req("a24_done_req", 6'b001011);
      tick(2);
      check_req("a24_latched", 6'b001011);
      cpu_as = 1'b1;
      vme_dtack = 1'b1;
      tick(2);
      check_req("a24_rel_e2", 6'b001011);
      tick(1);
      check_state("a24_rel_state", ST_IDLE);
      check_req("a24_rel_req", 6'b111111);

      // --- A16 cycle with no DTACK: watchdog fires 16 clocks after entry ---
      cpu_address = 16'hFFFF;
      cpu_as = 1'b0;
      tick(3);
      check_state("to_entry", ST_ACTIVE);
      tick(15);
      check_state("to_15", ST_ACTIVE);
      check_req("to_15_req", 6'b000111);
      tick(1);
      check_state("to_16", ST_TIMEOUT);
      check("to_berr", {15'd0, timeout_berr}, 16'd0);
      check("to_rsync", {15'd0, request_vme_sync}, 16'd0);
      cpu_as = 1'b1;
      tick(2);
      check("to_hold_berr", {15'd0, timeout_berr}, 16'd0);
      tick(1);
      check_state("to_rel_state", ST_IDLE);
      check_req("to_rel_req", 6'b111111);

      // --- Unmapped address: IGNORE, outputs stay inactive ---
      cpu_address = 16'h0123;
      cpu_as = 1'b0;
      tick(3);
      check_state("ign_state", ST_IGNORE);
      check_req("ign_req_a", 6'b111111);
      tick(5);
      check_req("ign_req_b", 6'b111111);
      cpu_as = 1'b1;
      tick(3);
      check_state("ign_idle", ST_IDLE);
      check_req("ign_req_c", 6'b111111);

      // --- A40 cycle: DTACK sync and terminal count on the same edge ---
      cpu_address = 16'hFD00;
      cpu_as = 1'b0;
      tick(3);
      check_state("tie_entry", ST_ACTIVE);
      check_req("tie_req", 6'b001101);
      tick(13);
      vme_dtack = 1'b0;
      tick(2);
      check_state("tie_pre", ST_ACTIVE);
      check("tie_dtack_s", {15'd0, vme_dtack_sync}, 16'd0);
      tick(1);
      check_state("tie_done", ST_DONE);
      check_req("tie_done_req", 6'b001101);

      // --- Back-to-back: one-clock AS high in the sync domain ---
      cpu_as = 1'b1;
      vme_dtack = 1'b1;
      tick(1);
      cpu_as = 1'b0;
      tick(1);
      check("b2b_as_high", {15'd0, cpu_as_sync}, 16'd1);
      tick(1);
      check_state("b2b_idle", ST_IDLE);
      check_req("b2b_idle_req", 6'b111111);
      tick(1);
      check_state("b2b_active", ST_ACTIVE);
      check_req("b2b_req", 6'b001101);

      // --- Reset pulsed in ACTIVE: all inactive on the next edge ---
      reset = 1'b1;
      tick(1);
      check_state("mid_rst_state", ST_IDLE);
      check_req("mid_rst_req", 6'b111111);
      check_syncs("mid_rst_syncs", 5'b11111);
      reset = 1'b0;

      // --- BERR terminates an A16 cycle ---
      cpu_address = 16'hFFFF;
      tick(3);
      check_state("berr_entry", ST_ACTIVE);
      vme_berr = 1'b0;
      tick(2);
      check("berr_sync", {15'd0, vme_berr_sync}, 16'd0);
      tick(1);
      check_state("berr_done", ST_DONE);
      check_req("berr_req", 6'b000111);
      cpu_as = 1'b1;
      vme_berr = 1'b1;
      tick(3);
      check_state("berr_idle", ST_IDLE);
      check_req("berr_rel", 6'b111111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
